regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file: next generation of the core's 2-read/1-write register file.
- Configurable width, depth, read-port count and write-port count; optional hard-wired zero register; optional same-cycle write-to-read bypass.
- Adds synchronous reset of the register contents and a per-register pending scoreboard, giving hazard status to issue logic.
- Sits between decode/issue (read and issue ports) and writeback (write ports).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers (power of two, ≥2). Local AW = $clog2(NREGS).
- NRD, 2, number of read ports (≥1).
- NWR, 2, number of write ports (≥1).
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and issues.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock, all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rs  in  NRD*AW  read addresses; port j is bits [j*AW +: AW].
- rd  out  NRD*XLEN  read data; port j is bits [j*XLEN +: XLEN].
- busy  out  NRD  busy[j] = register rs[j] has an outstanding write.
- we  in  NWR  write enables.
- waddr  in  NWR*AW  write addresses.
- wd  in  NWR*XLEN  write data.
- issue_valid  in  1  marks register issue_rd pending.
- issue_rd  in  AW  destination register being issued.
- any_pending  out  1  OR of all pending bits.

Behaviour:
- State: regs[NREGS] of XLEN bits; pending[NREGS] bits. No other storage.
- Reset: when reset is high at a clock edge, all regs become 0 and all pending bits become 0. Reset overrides writes and issues in the same cycle. From the cycle after reset, all rd = 0, busy = 0, any_pending = 0.
- Write: at the edge, for each i with we[i] = 1, regs[waddr[i]] <= wd[i]. With ZERO_REG = 1, writes to address 0 are dropped.
  - If several ports write the same address in one cycle, the highest-index port wins.
- Read: combinational, with zero cycles of latency. rd[j] = regs[rs[j]].
  - With BYPASS = 1: if any port i has we[i] = 1, waddr[i] == rs[j], and the write is not dropped, then rd[j] = wd[i]. When several ports match, the highest index wins.
  - With ZERO_REG = 1: rs[j] == 0 gives rd[j] = 0 regardless of any write or bypass.
  - With BYPASS = 0: rd shows the old value during the write cycle and the new value from the next cycle.
- Scoreboard set: at the edge, issue_valid = 1 sets pending[issue_rd]. With ZERO_REG = 1, an issue to register 0 has no effect.
- Scoreboard clear: at the edge, each non-dropped write clears pending[waddr[i]].
  - If a set and a clear hit the same register in one cycle, the set wins, because a newer producer has been issued. The write data is still stored.
  - A clear of a non-pending register is legal and leaves it at 0.
- busy[j] = pending[rs[j]]. With BYPASS = 1, busy[j] is additionally forced low when a bypass hit exists for port j that cycle. With ZERO_REG = 1, busy[j] = 0 for rs[j] = 0.
- any_pending = |pending, computed combinationally from registered state.
- Out-of-range addresses cannot occur, since NREGS is a power of two.
- X-free: all state is defined after one reset cycle.

Test Plan:
- Reset clears state: load reg 5 = 0xDEADBEEF and issue reg 7, then assert reset for 1 cycle → rd for rs = 5 reads 0, busy = 0, any_pending = 0.
- Write/read with bypass: we[0] = 1, waddr[0] = 3, wd[0] = 0x12345678 and rs[0] = 3 in the same cycle → rd[0] = 0x12345678 in that cycle. With BYPASS = 0, rd[0] = the old value that cycle and 0x12345678 in the next.
- Dual-write collision: ports 0 and 1 both write reg 9, with 0x1111 and 0x2222 → reg 9 = 0x2222, and the same-cycle bypass also shows 0x2222.
- Zero register: write 0xFFFFFFFF to reg 0 and issue reg 0 → rd for rs = 0 stays 0, busy = 0, any_pending = 0.
- Scoreboard lifecycle: issue reg 4 → next cycle busy for rs = 4 is 1 and any_pending = 1. Write reg 4 = 0xA5 → in that cycle busy = 0 (bypass) and rd = 0xA5; next cycle pending is clear and any_pending = 0.
- Set/clear race: pending[6] = 1, then in one cycle issue reg 6 and write reg 6 = 0x77 → next cycle pending[6] = 1, reg 6 = 0x77, busy for rs = 6 is 1.

Source files
------------

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bundles the register file's read, write and issue signals.
//
//   master : issue/writeback side. Drives addresses, write data and issue
//            requests. Receives read data, busy flags and any_pending.
//   slave  : the register file itself.
//
// Signals (AW = $clog2(NREGS)):
//   rs          NRD*AW    read addresses, port j = [j*AW +: AW]
//   rd          NRD*XLEN  read data,     port j = [j*XLEN +: XLEN]
//   busy        NRD       register rs[j] has an outstanding write
//   we          NWR       write enables
//   waddr       NWR*AW    write addresses
//   wd          NWR*XLEN  write data
//   issue_valid 1         mark issue_rd pending
//   issue_rd    AW        destination register being issued
//   any_pending 1         OR of all pending bits
// -----------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rs;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      busy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wd;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                any_pending;

    modport master (
        output rs, we, waddr, wd, issue_valid, issue_rd,
        input  rd, busy, any_pending
    );

    modport slave (
        input  rs, we, waddr, wd, issue_valid, issue_rd,
        output rd, busy, any_pending
    );
endinterface

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file with a per-register pending
// scoreboard for issue hazard tracking.
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  synchronous, active-high; clears registers and pending bits
//   bus    regfile_mp_if.slave (read ports, write ports, issue port, status)
//
// Parameters:
//   XLEN      data width
//   NREGS     register count (power of two, >= 2)
//   NRD/NWR   read / write port counts
//   ZERO_REG  1: register 0 reads 0 and ignores writes and issues
//   BYPASS    1: same-cycle writes are forwarded to matching read ports
//
// Priority rules: among colliding write ports the highest index wins, for
// both storage and bypass. An issue beats a write-clear on the same register
// because the issue belongs to a newer producer.
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] pending;

    // Unpacked views of the flat port vectors.
    logic [AW-1:0]   waddr_a [NWR];
    logic [XLEN-1:0] wd_a    [NWR];
    logic [AW-1:0]   rs_a    [NRD];
    logic [NWR-1:0]  wr_ok;      // write enabled and not dropped by ZERO_REG
    logic            issue_ok;

    logic [NRD*XLEN-1:0] rd_v;
    logic [NRD-1:0]      busy_v;

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        wr_ok    = '0;
        issue_ok = bus.issue_valid && !(ZERO_REG && (bus.issue_rd == '0));
        for (int i = 0; i < NWR; i++) begin
            waddr_a[i] = bus.waddr[i*AW +: AW];
            wd_a[i]    = bus.wd[i*XLEN +: XLEN];
            wr_ok[i]   = bus.we[i] && !(ZERO_REG && (waddr_a[i] == '0));
        end
        for (int j = 0; j < NRD; j++) begin
            rs_a[j] = bus.rs[j*AW +: AW];
        end
    end

    // State update. Ports are visited in ascending order, so a later (higher
    // index) write to the same address overrides an earlier one, and the
    // issue set placed after the write loop overrides any clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the register array is reset explicitly because its
            // contents must be zero after reset; this keeps it as flops
            // rather than a RAM macro, which is intended at this size.
            for (int k = 0; k < NREGS; k++) begin
                regs[k] <= '0;
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_ok[i]) begin
                    // NOTE: sequential state uses non-blocking assignments so
                    // every read in this block sees pre-edge values.
                    regs[waddr_a[i]]    <= wd_a[i];
                    pending[waddr_a[i]] <= 1'b0;
                end
            end
            if (issue_ok) begin
                pending[bus.issue_rd] <= 1'b1;
            end
        end
    end

    // Combinational read with optional bypass; the zero-register override is
    // applied last so it beats any bypass hit.
    always_comb begin
        rd_v   = '0;
        busy_v = '0;
        for (int j = 0; j < NRD; j++) begin
            rd_v[j*XLEN +: XLEN] = regs[rs_a[j]];
            busy_v[j]            = pending[rs_a[j]];
            if (BYPASS) begin
                for (int i = 0; i < NWR; i++) begin
                    if (wr_ok[i] && (waddr_a[i] == rs_a[j])) begin
                        rd_v[j*XLEN +: XLEN] = wd_a[i];
                        busy_v[j]            = 1'b0;
                    end
                end
            end
            if (ZERO_REG && (rs_a[j] == '0)) begin
                rd_v[j*XLEN +: XLEN] = '0;
                busy_v[j]            = 1'b0;
            end
        end
    end

    assign bus.rd          = rd_v;
    assign bus.busy        = busy_v;
    assign bus.any_pending = |pending;

endmodule
